// File: rtl/btn_pkg.sv
// Shared definitions for the push-button counter: default board timing,
// the auto-repeat state encoding and the wrap-around count helpers.
package btn_pkg;

    // Default timing for a 100 MHz board clock.
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms of stable samples
    localparam int DEF_REPEAT_DELAY    = 100_000_000; // 1 s before the first repeat
    localparam int DEF_REPEAT_PERIOD   = 25_000_000;  // 250 ms between repeats
    localparam int DEF_MAX_COUNT       = 9;           // highest value shown on the LEDs

    // Auto-repeat state encoding, one FSM per button.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEAT    = 2'd2
    } rep_state_t;

    // Step up with wrap from max_value back to zero.
    function automatic logic [3:0] wrap_inc(input logic [3:0] value, input logic [3:0] max_value);
        return (value == max_value) ? 4'd0 : value + 4'd1;
    endfunction

    // Step down with wrap from zero up to max_value.
    function automatic logic [3:0] wrap_dec(input logic [3:0] value, input logic [3:0] max_value);
        return (value == 4'd0) ? max_value : value - 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchroniser, debounce counter,
// press edge detect and auto-repeat FSM, producing a single step strobe.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic step
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_q;
    logic [DB_W-1:0]  db_cnt;
    rep_state_t       state;
    logic [RPT_W-1:0] rpt_cnt;
    logic             press;
    logic             rep;

    // Synchronise the raw pin and accept a new level only after DEBOUNCE_CYCLES
    // consecutive samples disagree with the current debounced level.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= ~level;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Press is the debounced rising edge; repeat fires when the hold counter hits its limit.
    always_comb begin
        press = level & ~level_q;
        rep   = 1'b0;
        if (level) begin
            if (state == HOLD_WAIT && rpt_cnt == DELAY_LAST) begin
                rep = 1'b1;
            end else if (state == REPEAT && rpt_cnt == PERIOD_LAST) begin
                rep = 1'b1;
            end
        end
    end

    // Auto-repeat FSM with a registered step strobe; a release always returns to IDLE silently.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            rpt_cnt <= '0;
            step    <= 1'b0;
        end else begin
            step <= press | rep;
            case (state)
                IDLE: begin
                    rpt_cnt <= '0;
                    if (press) begin
                        state <= HOLD_WAIT;
                    end
                end
                HOLD_WAIT: begin
                    if (!level) begin
                        state   <= IDLE;
                        rpt_cnt <= '0;
                    end else if (rpt_cnt == DELAY_LAST) begin
                        state   <= REPEAT;
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!level) begin
                        state   <= IDLE;
                        rpt_cnt <= '0;
                    end else if (rpt_cnt == PERIOD_LAST) begin
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rpt_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_count.sv
// Up/down push-button counter: two debounced, auto-repeating button front
// ends drive a 0..MAX_COUNT wrap-around value shown on the board LEDs.
module btn_count
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int MAX_COUNT       = DEF_MAX_COUNT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [3:0] led,
    output logic       up_pulse,
    output logic       dn_pulse
);

    localparam logic [3:0] MAX_LED = 4'(MAX_COUNT);

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_up (
        .clk (clk),
        .clr (clr),
        .btn (btn_up),
        .step(up_pulse)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_dn (
        .clk (clk),
        .clr (clr),
        .btn (btn_dn),
        .step(dn_pulse)
    );

    // Wrap-around count; simultaneous up and down strobes cancel out.
    always_ff @(posedge clk) begin
        if (clr) begin
            led <= 4'd0;
        end else if (up_pulse && !dn_pulse) begin
            led <= wrap_inc(led, MAX_LED);
        end else if (dn_pulse && !up_pulse) begin
            led <= wrap_dec(led, MAX_LED);
        end
    end

endmodule

// File: tb/tb_btn_count.sv
// Self-checking bench for btn_count: directed scenarios plus random button
// activity, every cycle compared against a behavioural model of the buttons.
module tb_btn_count;

    localparam int DB   = 4;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int MAXC = 9;

    logic       clk    = 1'b0;
    logic       clr    = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic [3:0] led;
    logic       up_pulse;
    logic       dn_pulse;

    int checks   = 0;
    int failures = 0;

    // Model state, index 0 = up button, 1 = down button.
    bit [1:0] m_dly      [2];
    bit       m_lvl      [2];
    bit       m_lvl_prev [2];
    int       m_run      [2];
    bit       m_hold     [2];
    int       m_age      [2];
    bit       m_step     [2];
    int       m_led;

    int edge_no    = 0;
    int up_total   = 0;
    int dn_total   = 0;
    int both_total = 0;
    int dn_edges[$];

    always #5 clk = ~clk;

    btn_count #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .MAX_COUNT      (MAXC)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .led     (led),
        .up_pulse(up_pulse),
        .dn_pulse(dn_pulse)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", tag, actual, expected, edge_no);
        end
    endtask

    // Advance the model by one rising edge with the inputs sampled on that edge.
    task automatic modelEdge(input bit c, input bit u, input bit d);
        bit raw [2];
        bit prev_up;
        bit prev_dn;
        bit seen;
        bit press;
        bit rep;
        raw[0]  = u;
        raw[1]  = d;
        prev_up = m_step[0];
        prev_dn = m_step[1];
        if (c) begin
            for (int b = 0; b < 2; b++) begin
                m_dly[b] = 2'b00; m_lvl[b] = 0; m_lvl_prev[b] = 0; m_run[b] = 0;
                m_hold[b] = 0; m_age[b] = 0; m_step[b] = 0;
            end
            m_led = 0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                seen  = m_dly[b][1];
                press = m_lvl[b] && !m_lvl_prev[b];
                rep   = 0;
                if (m_hold[b] && m_lvl[b]) begin
                    m_age[b]++;
                    rep = (m_age[b] >= RD) && (((m_age[b] - RD) % RP) == 0);
                end else begin
                    m_hold[b] = 0;
                end
                if (press) begin
                    m_hold[b] = 1;
                    m_age[b]  = 0;
                end
                m_step[b]     = press || rep;
                m_lvl_prev[b] = m_lvl[b];
                if (seen != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_lvl[b] = !m_lvl[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_dly[b] = {m_dly[b][0], raw[b]};
            end
            if (prev_up && !prev_dn) m_led = (m_led + 1) % (MAXC + 1);
            else if (prev_dn && !prev_up) m_led = (m_led + MAXC) % (MAXC + 1);
        end
    endtask

    // One clock: drive on the falling edge, update model on the rising edge, compare just after.
    task automatic tick(input bit c, input bit u, input bit d);
        @(negedge clk);
        clr    = c;
        btn_up = u;
        btn_dn = d;
        @(posedge clk);
        modelEdge(c, u, d);
        #1;
        edge_no++;
        checkOutput("up_pulse", up_pulse, m_step[0]);
        checkOutput("dn_pulse", dn_pulse, m_step[1]);
        checkOutput("led", led, m_led);
        if (up_pulse === 1'b1) up_total++;
        if (dn_pulse === 1'b1) begin
            dn_total++;
            dn_edges.push_back(edge_no);
        end
        if (up_pulse === 1'b1 && dn_pulse === 1'b1) both_total++;
    endtask

    task automatic applyStimulus(input bit c, input bit u, input bit d, input int n);
        for (int i = 0; i < n; i++) tick(c, u, d);
    endtask

    // Short clean press followed by a long release, well below the repeat delay.
    task automatic cleanPress(input bit u, input bit d);
        applyStimulus(0, u, d, 6);
        applyStimulus(0, 0, 0, 12);
    endtask

    initial begin
        int first;
        int base;
        int s0;
        int s1;
        int s2;
        int len;
        bit c;
        bit u;
        bit d;

        // Reset with up held, then a held button needs a full debounce window.
        applyStimulus(1, 1, 0, 3);
        checkOutput("reset_led", led, 0);
        checkOutput("reset_up_pulse", up_pulse, 0);
        first = 0;
        for (int k = 1; k <= 20 && first == 0; k++) begin
            tick(0, 1, 0);
            if (up_pulse === 1'b1) first = k;
        end
        checkOutput("first_up_latency", first, 7);
        tick(0, 1, 0);
        checkOutput("led_after_first_press", led, 1);
        applyStimulus(0, 0, 0, 16);

        // Glitch rejection, then a minimal 4-cycle press.
        applyStimulus(1, 0, 0, 1);
        base = up_total;
        applyStimulus(0, 1, 0, 3);
        applyStimulus(0, 0, 0, 12);
        checkOutput("glitch_pulses", up_total - base, 0);
        checkOutput("glitch_led", led, 0);
        base = up_total;
        applyStimulus(0, 1, 0, 4);
        applyStimulus(0, 0, 0, 12);
        checkOutput("min_press_pulses", up_total - base, 1);
        checkOutput("min_press_led", led, 1);

        // Wrap upward through 9 to 0, then down from 0 to 9.
        applyStimulus(1, 0, 0, 1);
        for (int i = 1; i <= 10; i++) begin
            cleanPress(1, 0);
            checkOutput("wrap_up_led", led, i % 10);
        end
        cleanPress(0, 1);
        checkOutput("wrap_dn_led", led, 9);

        // Auto-repeat on a 60-cycle down hold starting at 5.
        applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) cleanPress(1, 0);
        checkOutput("led_before_repeat", led, 5);
        dn_edges.delete();
        base = edge_no;
        applyStimulus(0, 0, 1, 60);
        applyStimulus(0, 0, 0, 20);
        s0 = -1; s1 = -1; s2 = -1;
        if (dn_edges.size() > 0) s0 = dn_edges[0] - base;
        if (dn_edges.size() > 1) s1 = dn_edges[1] - dn_edges[0];
        if (dn_edges.size() > 2) s2 = dn_edges[2] - dn_edges[1];
        checkOutput("repeat_press_latency", s0, 7);
        checkOutput("repeat_first_delay", s1, 20);
        checkOutput("repeat_period", s2, 5);
        checkOutput("repeat_pulse_count", dn_edges.size(), 9);
        checkOutput("repeat_final_led", led, 6);

        // Simultaneous presses cancel; presses one cycle apart net to zero.
        base = both_total;
        cleanPress(1, 1);
        checkOutput("simultaneous_both", both_total - base, 1);
        checkOutput("simultaneous_led", led, 6);
        tick(0, 1, 0);
        applyStimulus(0, 1, 1, 5);
        applyStimulus(0, 0, 0, 14);
        checkOutput("staggered_led", led, 6);

        // Reset in the middle of auto-repeat with the button still held.
        applyStimulus(0, 1, 0, 35);
        tick(1, 1, 0);
        checkOutput("mid_repeat_clr_led", led, 0);
        base = up_total;
        applyStimulus(0, 1, 0, 6);
        checkOutput("no_pulse_after_clr", up_total - base, 0);
        tick(0, 1, 0);
        checkOutput("new_press_after_clr", up_pulse, 1);
        applyStimulus(0, 0, 0, 20);

        // Random button activity with occasional resets.
        for (int s = 0; s < 120; s++) begin
            c   = ($urandom_range(0, 15) == 0);
            len = c ? $urandom_range(1, 2) : $urandom_range(1, 40);
            u   = $urandom_range(0, 1);
            d   = $urandom_range(0, 1);
            applyStimulus(c, u, d, len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
